// File: rtl/peak_pkg.sv
// Shared types for the spectral peak picker: ranked entry layout and FSM states.
package peak_pkg;

    localparam int PEAK_BIN_W   = 9;
    localparam int PEAK_MAG_W   = 16;
    localparam int PEAK_ENTRY_W = PEAK_BIN_W + PEAK_MAG_W;

    typedef struct packed {
        logic [PEAK_BIN_W-1:0] bin;
        logic [PEAK_MAG_W-1:0] mag;
    } peak_entry_t;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FLUSH   = 2'd1,
        PUBLISH = 2'd2
    } peak_state_t;

endpackage

// File: rtl/peak_sorted_list.sv
// K-entry descending insertion-sort list of {bin, mag}; one insertion per cycle.
module peak_sorted_list #(
    parameter int K     = 10,
    parameter int BIN_W = 9,
    parameter int MAG_W = 16,
    parameter int CNT_W = $clog2(K + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear,
    input  logic                            insert,
    input  logic [BIN_W-1:0]                in_bin,
    input  logic [MAG_W-1:0]                in_mag,
    output logic [K-1:0][BIN_W+MAG_W-1:0]   entries,
    output logic [CNT_W-1:0]                count,
    output logic                            full
);

    localparam int EW = BIN_W + MAG_W;

    logic [K-1:0][EW-1:0] entries_r;
    logic [K-1:0][EW-1:0] prev_s;
    logic [K-1:0]         vld_r;
    logic [K-1:0]         vld_prev_s;
    logic [K-1:0]         gt_s;
    logic [K-1:0]         above_s;
    logic [CNT_W-1:0]     count_r;

    // Slot i yields when empty or strictly smaller, so equal magnitudes keep the earlier bin above.
    always_comb begin
        gt_s = '0;
        for (int i = 0; i < K; i++) begin
            gt_s[i] = !vld_r[i] || (in_mag > entries_r[i][MAG_W-1:0]);
        end
        above_s    = {gt_s[K-2:0], 1'b0};
        prev_s     = {entries_r[K-2:0], {EW{1'b0}}};
        vld_prev_s = {vld_r[K-2:0], 1'b0};
    end

    // Parallel compare-and-shift insertion; the bottom entry falls off when the list is full.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            entries_r <= '0;
            vld_r     <= '0;
            count_r   <= '0;
        end else if (insert && gt_s[K-1]) begin
            for (int i = 0; i < K; i++) begin
                if (gt_s[i] && !above_s[i]) begin
                    entries_r[i] <= {in_bin, in_mag};
                    vld_r[i]     <= 1'b1;
                end else if (gt_s[i]) begin
                    entries_r[i] <= prev_s[i];
                    vld_r[i]     <= vld_prev_s[i];
                end
            end
            if (count_r != CNT_W'(K)) begin
                count_r <= count_r + CNT_W'(1);
            end
        end
    end

    assign entries = entries_r;
    assign count   = count_r;
    assign full    = (count_r == CNT_W'(K));

endmodule

// File: rtl/spectral_peak_picker.sv
// Streaming top-K spectral peak picker publishing a sorted {bin, mag} list per frame.
// Define PEAK_LOCAL_MAX_EN to rank only local maxima instead of every sample above threshold.
module spectral_peak_picker
    import peak_pkg::*;
#(
    parameter int MAXIMAS_COUNT = 10,
    parameter int BIN_W         = 9,
    parameter int MAG_W         = 16
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        mag_valid,
    output logic                                        mag_ready,
    input  logic [MAG_W-1:0]                            mag_data,
    input  logic                                        mag_last,
    input  logic [MAG_W-1:0]                            threshold,
    output logic [MAXIMAS_COUNT-1:0][BIN_W+MAG_W-1:0]   maximas,
    output logic [$clog2(MAXIMAS_COUNT+1)-1:0]          maximas_count,
    output logic                                        maximas_found_active
);

    localparam int EW    = BIN_W + MAG_W;
    localparam int CNT_W = $clog2(MAXIMAS_COUNT + 1);

    peak_state_t                          state_r;
    logic [BIN_W-1:0]                     bin_r;
    logic [MAXIMAS_COUNT-1:0][EW-1:0]     maximas_r;
    logic [CNT_W-1:0]                     maximas_count_r;
    logic                                 found_r;
    logic                                 accept_s;
    logic                                 ins_s;
    logic                                 list_insert_s;
    logic [BIN_W-1:0]                     ins_bin_s;
    logic [MAG_W-1:0]                     ins_mag_s;
    logic [MAXIMAS_COUNT-1:0][EW-1:0]     list_entries_s;
    logic [CNT_W-1:0]                     list_count_s;
    logic                                 list_full_s;

    assign mag_ready = (state_r == COLLECT);
    assign accept_s  = mag_valid && mag_ready;

`ifdef PEAK_LOCAL_MAX_EN
    logic [MAG_W-1:0] prev_mag_r;
    logic [MAG_W-1:0] cur_mag_r;
    logic [MAG_W-1:0] cur_thr_r;
    logic [BIN_W-1:0] cur_bin_r;
    logic             pend_r;
    logic             cand_s;

    // Bin k is judged once its right neighbour arrives, or in FLUSH against an implicit zero.
    always_comb begin
        ins_bin_s = cur_bin_r;
        ins_mag_s = cur_mag_r;
        cand_s    = pend_r && (cur_mag_r > prev_mag_r) && (cur_mag_r > cur_thr_r);
        if (accept_s) begin
            ins_s = cand_s && (cur_mag_r >= mag_data);
        end else if (state_r == FLUSH) begin
            ins_s = cand_s;
        end else begin
            ins_s = 1'b0;
        end
    end

    // Neighbour window: left magnitude, pending bin and the threshold it arrived with.
    always_ff @(posedge clk) begin
        if (!reset || (state_r == PUBLISH)) begin
            prev_mag_r <= '0;
            cur_mag_r  <= '0;
            cur_thr_r  <= '0;
            cur_bin_r  <= '0;
            pend_r     <= 1'b0;
        end else if (accept_s) begin
            prev_mag_r <= cur_mag_r;
            cur_mag_r  <= mag_data;
            cur_thr_r  <= threshold;
            cur_bin_r  <= bin_r;
            pend_r     <= 1'b1;
        end
    end
`else
    // Every accepted sample above threshold is a candidate in its own cycle.
    always_comb begin
        ins_bin_s = bin_r;
        ins_mag_s = mag_data;
        ins_s     = accept_s && (mag_data > threshold);
    end
`endif

    // A full list only admits candidates that beat its lowest entry.
    assign list_insert_s = ins_s &&
        (!list_full_s || (ins_mag_s > list_entries_s[MAXIMAS_COUNT-1][MAG_W-1:0]));

    peak_sorted_list #(
        .K     (MAXIMAS_COUNT),
        .BIN_W (BIN_W),
        .MAG_W (MAG_W),
        .CNT_W (CNT_W)
    ) u_list (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_r == PUBLISH),
        .insert  (list_insert_s),
        .in_bin  (ins_bin_s),
        .in_mag  (ins_mag_s),
        .entries (list_entries_s),
        .count   (list_count_s),
        .full    (list_full_s)
    );

    // Frame FSM, saturating bin counter and published output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r         <= COLLECT;
            bin_r           <= '0;
            maximas_r       <= '0;
            maximas_count_r <= '0;
            found_r         <= 1'b0;
        end else begin
            found_r <= 1'b0;
            case (state_r)
                COLLECT: begin
                    if (accept_s) begin
                        if (bin_r != {BIN_W{1'b1}}) begin
                            bin_r <= bin_r + BIN_W'(1);
                        end
                        if (mag_last) begin
                            state_r <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    state_r <= PUBLISH;
                end
                PUBLISH: begin
                    maximas_r       <= list_entries_s;
                    maximas_count_r <= list_count_s;
                    found_r         <= 1'b1;
                    bin_r           <= '0;
                    state_r         <= COLLECT;
                end
                default: begin
                    state_r <= COLLECT;
                end
            endcase
        end
    end

    assign maximas              = maximas_r;
    assign maximas_count        = maximas_count_r;
    assign maximas_found_active = found_r;

endmodule

// File: tb/tb_spectral_peak_picker.sv
// Directed bench for spectral_peak_picker (K=4 main instance, K=2 overflow instance).
module tb_spectral_peak_picker;
    import peak_pkg::*;

    localparam int K = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              mag_valid;
    logic              mag_ready;
    logic              mag_ready2;
    logic [15:0]       mag_data;
    logic              mag_last;
    logic [15:0]       threshold;
    logic [K-1:0][24:0] maximas;
    logic [2:0]        maximas_count;
    logic              found;
    logic [1:0][24:0]  maximas2;
    logic [1:0]        maximas_count2;
    logic              found2;

    int checks = 0;
    int failures = 0;
    int pulse_cnt = 0;
    int lowcnt = 0;

    always #5 clk = ~clk;

    spectral_peak_picker #(.MAXIMAS_COUNT(K), .BIN_W(9), .MAG_W(16)) dut (
        .clk(clk), .reset(reset), .mag_valid(mag_valid), .mag_ready(mag_ready),
        .mag_data(mag_data), .mag_last(mag_last), .threshold(threshold),
        .maximas(maximas), .maximas_count(maximas_count), .maximas_found_active(found)
    );

    spectral_peak_picker #(.MAXIMAS_COUNT(2), .BIN_W(9), .MAG_W(16)) dut2 (
        .clk(clk), .reset(reset), .mag_valid(mag_valid), .mag_ready(mag_ready2),
        .mag_data(mag_data), .mag_last(mag_last), .threshold(threshold),
        .maximas(maximas2), .maximas_count(maximas_count2), .maximas_found_active(found2)
    );

    always @(posedge clk) if (found === 1'b1) pulse_cnt++;

    typedef struct packed {
        logic [0:7][15:0] mags;
        logic [3:0]       len;
        logic [15:0]      thr;
        logic [0:3][24:0] exp;
        logic [2:0]       cnt;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [24:0] ent(input int b, input int m);
        peak_entry_t e;
        e.bin = b[8:0];
        e.mag = m[15:0];
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        int g;
        g = 0;
        mag_valid = 1'b1;
        mag_data  = d;
        mag_last  = l;
        while (mag_ready !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
            lowcnt++;
        end
        if (g >= 20) check("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_pulse(input string name, input int req_lat);
        int n;
        n = 0;
        while (found !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n), 32'(req_lat));
    endtask

    task automatic apply_vec(input vec_t v, input int id);
        int len;
        len = int'(v.len);
        threshold = v.thr;
        for (int i = 0; i < len; i++) send(v.mags[i], (i == len - 1));
        mag_valid = 1'b0;
        mag_last  = 1'b0;
        wait_pulse($sformatf("v%0d_latency", id), 2);
        for (int e = 0; e < K; e++)
            check($sformatf("v%0d_entry%0d", id, e), 32'(maximas[e]), 32'(v.exp[e]));
        check($sformatf("v%0d_count", id), 32'(maximas_count), 32'(v.cnt));
        check($sformatf("v%0d_ready", id), 32'(mag_ready), 32'd1);
        @(negedge clk);
        check($sformatf("v%0d_pulse_width", id), 32'(found), 32'd0);
    endtask

    initial begin
        int p0;
        vecs[0].mags = {16'd0, 16'd3, 16'd7, 16'd2, 16'd9, 16'd9, 16'd1, 16'd5};
        vecs[0].len = 4'd8; vecs[0].thr = 16'd0;
        vecs[1].mags = vecs[0].mags;
        vecs[1].len = 4'd8; vecs[1].thr = 16'd6;
        vecs[2].mags = {16'd5, 16'd5, 16'd5, 16'd5, 16'd0, 16'd0, 16'd0, 16'd0};
        vecs[2].len = 4'd4; vecs[2].thr = 16'd0;
        vecs[3].mags = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd0, 16'd0};
        vecs[3].len = 4'd6; vecs[3].thr = 16'd0;
        vecs[4].mags = {16'd10, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        vecs[4].len = 4'd1; vecs[4].thr = 16'd3;
        vecs[4].exp = {ent(0, 10), 25'd0, 25'd0, 25'd0}; vecs[4].cnt = 3'd1;
        vecs[5].mags = {16'd1, 16'd8, 16'd2, 16'd6, 16'd3, 16'd9, 16'd0, 16'd0};
        vecs[5].len = 4'd7; vecs[5].thr = 16'd0;
`ifdef PEAK_LOCAL_MAX_EN
        vecs[0].exp = {ent(4, 9), ent(2, 7), ent(7, 5), 25'd0};  vecs[0].cnt = 3'd3;
        vecs[1].exp = {ent(4, 9), ent(2, 7), 25'd0, 25'd0};      vecs[1].cnt = 3'd2;
        vecs[2].exp = {ent(0, 5), 25'd0, 25'd0, 25'd0};          vecs[2].cnt = 3'd1;
        vecs[3].exp = {ent(5, 6), 25'd0, 25'd0, 25'd0};          vecs[3].cnt = 3'd1;
        vecs[5].exp = {ent(5, 9), ent(1, 8), ent(3, 6), 25'd0};  vecs[5].cnt = 3'd3;
`else
        vecs[0].exp = {ent(4, 9), ent(5, 9), ent(2, 7), ent(7, 5)}; vecs[0].cnt = 3'd4;
        vecs[1].exp = {ent(4, 9), ent(5, 9), ent(2, 7), 25'd0};     vecs[1].cnt = 3'd3;
        vecs[2].exp = {ent(0, 5), ent(1, 5), ent(2, 5), ent(3, 5)}; vecs[2].cnt = 3'd4;
        vecs[3].exp = {ent(5, 6), ent(4, 5), ent(3, 4), ent(2, 3)}; vecs[3].cnt = 3'd4;
        vecs[5].exp = {ent(5, 9), ent(1, 8), ent(3, 6), ent(4, 3)}; vecs[5].cnt = 3'd4;
`endif

        // Reset state
        reset = 1'b0; mag_valid = 1'b0; mag_data = 16'd0; mag_last = 1'b0; threshold = 16'd0;
        repeat (3) @(negedge clk);
        for (int e = 0; e < K; e++) check($sformatf("rst_entry%0d", e), 32'(maximas[e]), 32'd0);
        check("rst_count", 32'(maximas_count), 32'd0);
        check("rst_pulse", 32'(found), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(mag_ready), 32'd1);

        // Table-driven frames
        for (int v = 0; v < 6; v++) apply_vec(vecs[v], v);
        check("ovf_entry0", 32'(maximas2[0]), 32'(ent(5, 9)));
        check("ovf_entry1", 32'(maximas2[1]), 32'(ent(1, 8)));
        check("ovf_count", 32'(maximas_count2), 32'd2);

        // Back-to-back frames with mag_valid held high across frame ends
        p0 = pulse_cnt; lowcnt = 0; threshold = 16'd0;
        for (int i = 0; i < 8; i++) send(vecs[0].mags[i], (i == 7));
        send(16'd0, 1'b0);
        check("b2b_ready_low_a", 32'(lowcnt), 32'd2);
        for (int e = 0; e < K; e++)
            check($sformatf("b2b_a_entry%0d", e), 32'(maximas[e]), 32'(vecs[0].exp[e]));
        send(16'd6, 1'b0);
        send(16'd0, 1'b1);
        send(16'd0, 1'b0);
        check("b2b_ready_low_b", 32'(lowcnt), 32'd4);
        check("b2b_b_entry0", 32'(maximas[0]), 32'(ent(1, 6)));
        check("b2b_b_entry1", 32'(maximas[1]), 32'd0);
        check("b2b_b_count", 32'(maximas_count), 32'd1);
        send(16'd0, 1'b1);
        mag_valid = 1'b0; mag_last = 1'b0;
        wait_pulse("b2b_c_latency", 2);
        @(negedge clk);
        check("b2b_c_count", 32'(maximas_count), 32'd0);
        check("b2b_c_entry0", 32'(maximas[0]), 32'd0);
        check("b2b_pulses", 32'(pulse_cnt - p0), 32'd3);

        // Reset in the middle of a frame
        apply_vec(vecs[2], 6);
        threshold = 16'd0;
        send(16'd0, 1'b0); send(16'd3, 1'b0); send(16'd7, 1'b0);
        mag_valid = 1'b0;
        p0 = pulse_cnt;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int e = 0; e < K; e++) check($sformatf("mid_rst_entry%0d", e), 32'(maximas[e]), 32'd0);
        check("mid_rst_count", 32'(maximas_count), 32'd0);
        check("mid_rst_pulse", 32'(found), 32'd0);
        @(negedge clk);
        check("mid_rst_ready", 32'(mag_ready), 32'd1);
        repeat (4) @(negedge clk);
        check("mid_rst_no_pulse", 32'(pulse_cnt - p0), 32'd0);
        apply_vec(vecs[0], 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
